// File: rtl/ram_arb_pkg.sv
// Shared types for the two-master RAM arbiter: FSM states, master ids,
// and the round-robin owner choice used by the top level.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } ArbState;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Lone requester wins; on a tie the master that was not served last wins.
  function automatic logic pick_owner(input logic [1:0] req, input logic last);
    logic who;
    if (req == 2'b11) who = ~last;
    else if (req[M1]) who = M1;
    else              who = M0;
    return who;
  endfunction

endpackage

// File: rtl/ram_arb_port.sv
// Per-master front end: captures a single-cycle strobe into a request latch,
// holds it pending until the arbiter serves it, and generates rbusy/wbusy.
// A strobe is accepted when nothing is pending, or on the very edge the
// arbiter clears the pending request, so back-to-back requests lose no cycle.
module ram_arb_port
  import ram_arb_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_wmask,
  input  logic          i_rstrb,
  input  logic          i_clr,
  output logic          o_pend,
  output logic          o_pend_nxt,
  output logic          o_is_wr,
  output logic [AW-1:0] o_addr,
  output logic [31:0]   o_wdata,
  output logic [3:0]    o_wmask,
  output logic          o_rbusy,
  output logic          o_wbusy
);

  logic          r_pend;
  logic          r_is_wr;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wmask;
  logic          w_strobe;
  logic          w_accept;
  logic          w_pend_nxt;

  assign w_strobe   = i_rstrb | (|i_wmask);
  assign w_accept   = w_strobe & (~r_pend | i_clr);
  assign w_pend_nxt = ~reset & (w_accept | (r_pend & ~i_clr));

  // Pending flag and request latch; a strobe while pending is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend  <= 1'b0;
      r_is_wr <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_accept) begin
        r_is_wr <= |i_wmask;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_wmask <= i_wmask;
      end
    end
  end

  assign o_pend     = r_pend;
  assign o_pend_nxt = w_pend_nxt;
  assign o_is_wr    = r_is_wr;
  assign o_addr     = r_addr;
  assign o_wdata    = r_wdata;
  assign o_wmask    = r_wmask;
  assign o_rbusy    = r_pend & ~r_is_wr;
  assign o_wbusy    = r_pend & r_is_wr;

endmodule

// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port block RAM
// (M0 = CPU, M1 = UART loader). Optional statistics counters are built
// only when RAM_ARB_STATS_EN is defined; otherwise stat_* are tied to 0.
//
// Master handshake: a master raises m_rstrb or a nonzero m_wmask for exactly
// one cycle; the request is captured on that edge, busy (rbusy for reads,
// wbusy for writes) is high from the next cycle until the access completes,
// and for a read m_rdata is valid in the first cycle busy is low again.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW    = 14,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    m_addr  [2],
  input  logic [31:0]      m_wdata [2],
  input  logic [3:0]       m_wmask [2],
  input  logic             m_rstrb [2],
  output logic [31:0]      m_rdata [2],
  output logic             m_rbusy [2],
  output logic             m_wbusy [2],
  output logic [AW-1:0]    ram_addr,
  output logic [31:0]      ram_wdata,
  output logic [3:0]       ram_wmask,
  output logic             ram_en,
  input  logic [31:0]      ram_rdata,
  output logic [CNT_W-1:0] stat_grant [2],
  output logic [CNT_W-1:0] stat_conflict,
  output ArbState          o_dbg_state
);

  ArbState       r_state;
  ArbState       w_state_nxt;
  logic          r_owner;
  logic          w_owner_nxt;
  logic          r_last;
  logic [31:0]   r_rdata [2];

  logic [1:0]    w_pend;
  logic [1:0]    w_pend_nxt;
  logic [1:0]    w_is_wr;
  logic [1:0]    w_clr;
  logic [AW-1:0] w_l_addr  [2];
  logic [31:0]   w_l_wdata [2];
  logic [3:0]    w_l_wmask [2];
  logic          w_access;
  logic          w_resp;

  assign w_access = (r_state == ACCESS) & ~reset;
  assign w_resp   = (r_state == RESP) & ~reset;

  for (genvar g = 0; g < 2; g++) begin : g_port
    assign w_clr[g] = w_access && (r_owner == 1'(g)) && w_pend[g];

    ram_arb_port #(.AW(AW)) u_port (
      .clk        (clk),
      .reset      (reset),
      .i_addr     (m_addr[g]),
      .i_wdata    (m_wdata[g]),
      .i_wmask    (m_wmask[g]),
      .i_rstrb    (m_rstrb[g]),
      .i_clr      (w_clr[g]),
      .o_pend     (w_pend[g]),
      .o_pend_nxt (w_pend_nxt[g]),
      .o_is_wr    (w_is_wr[g]),
      .o_addr     (w_l_addr[g]),
      .o_wdata    (w_l_wdata[g]),
      .o_wmask    (w_l_wmask[g]),
      .o_rbusy    (m_rbusy[g]),
      .o_wbusy    (m_wbusy[g])
    );
  end

  // State, owner and last-served registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= M0;
      r_last  <= M1;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      if (r_state == ACCESS) r_last <= r_owner;
    end
  end

  // Next state and owner; decisions look at next-cycle pend so a fresh
  // strobe is served in the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      IDLE: begin
        if (|w_pend_nxt) begin
          w_state_nxt = ACCESS;
          w_owner_nxt = pick_owner(w_pend_nxt, r_last);
        end
      end
      ACCESS: begin
        if (w_is_wr[r_owner]) begin
          if (|w_pend_nxt) begin
            w_state_nxt = ACCESS;
            w_owner_nxt = pick_owner(w_pend_nxt, r_owner);
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (|w_pend_nxt) begin
          w_state_nxt = ACCESS;
          w_owner_nxt = pick_owner(w_pend_nxt, r_last);
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // RAM port mux: driven only during ACCESS, zero otherwise.
  always_comb begin
    ram_en    = w_access;
    ram_addr  = w_access ? w_l_addr[r_owner]  : '0;
    ram_wdata = w_access ? w_l_wdata[r_owner] : '0;
    ram_wmask = w_access ? w_l_wmask[r_owner] : '0;
  end

  // Read data passes through in RESP for the owner, otherwise holds.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      m_rdata[i] = (w_resp && (r_owner == 1'(i))) ? ram_rdata : r_rdata[i];
    end
  end

  // Hold register behind each m_rdata.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      r_rdata[i] <= reset ? '0 : m_rdata[i];
    end
  end

  assign o_dbg_state = r_state;

`ifdef RAM_ARB_STATS_EN
  logic [CNT_W-1:0] r_grant [2];
  logic [CNT_W-1:0] r_conflict;

  // Saturating grant and conflict counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant[0] <= '0;
      r_grant[1] <= '0;
      r_conflict <= '0;
    end else begin
      if (w_access && (r_grant[r_owner] != '1)) begin
        r_grant[r_owner] <= r_grant[r_owner] + CNT_W'(1);
      end
      if ((w_pend == 2'b11) && (r_conflict != '1)) begin
        r_conflict <= r_conflict + CNT_W'(1);
      end
    end
  end

  // Counter outputs.
  always_comb begin
    stat_grant[0] = r_grant[0];
    stat_grant[1] = r_grant[1];
    stat_conflict = r_conflict;
  end
`else
  // Statistics disabled: outputs tied low.
  always_comb begin
    stat_grant[0] = '0;
    stat_grant[1] = '0;
    stat_conflict = '0;
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, table-driven uncontended transactions,
// hand sequences for reset/contention/ignored strobes/alternation/stats,
// and a random two-master run against a shadow-memory reference.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int AW    = 14;
  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [AW-1:0]    m0_addr = '0, m1_addr = '0;
  logic [31:0]      m0_wdata = '0, m1_wdata = '0;
  logic [3:0]       m0_wmask = '0, m1_wmask = '0;
  logic             m0_rstrb = 1'b0, m1_rstrb = 1'b0;
  logic [AW-1:0]    m_addr  [2];
  logic [31:0]      m_wdata [2];
  logic [3:0]       m_wmask [2];
  logic             m_rstrb [2];
  logic [31:0]      m_rdata [2];
  logic             m_rbusy [2];
  logic             m_wbusy [2];
  logic [AW-1:0]    ram_addr;
  logic [31:0]      ram_wdata;
  logic [3:0]       ram_wmask;
  logic             ram_en;
  logic [31:0]      ram_rdata = '0;
  logic [CNT_W-1:0] stat_grant [2];
  logic [CNT_W-1:0] stat_conflict;
  ArbState          dbg_state;

  assign m_addr[0]  = m0_addr;   assign m_addr[1]  = m1_addr;
  assign m_wdata[0] = m0_wdata;  assign m_wdata[1] = m1_wdata;
  assign m_wmask[0] = m0_wmask;  assign m_wmask[1] = m1_wmask;
  assign m_rstrb[0] = m0_rstrb;  assign m_rstrb[1] = m1_rstrb;

  ram_arbiter #(.AW(AW), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .m_addr        (m_addr),
    .m_wdata       (m_wdata),
    .m_wmask       (m_wmask),
    .m_rstrb       (m_rstrb),
    .m_rdata       (m_rdata),
    .m_rbusy       (m_rbusy),
    .m_wbusy       (m_wbusy),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_wmask     (ram_wmask),
    .ram_en        (ram_en),
    .ram_rdata     (ram_rdata),
    .stat_grant    (stat_grant),
    .stat_conflict (stat_conflict),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- RAM model (registered read) ----------------
  logic [31:0] mem [0:(1<<AW)-1];
  int          wr30_cnt = 0;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wmask != 4'b0) begin
        for (int b = 0; b < 4; b++)
          if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        if (ram_addr == 14'h0030) wr30_cnt <= wr30_cnt + 1;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] shadow [0:(1<<AW)-1];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] wm, input logic rs);
    if (m == 0) begin
      m0_addr = a; m0_wdata = d; m0_wmask = wm; m0_rstrb = rs;
    end else begin
      m1_addr = a; m1_wdata = d; m1_wmask = wm; m1_rstrb = rs;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ram_en_in_reset", 32'(ram_en), 32'd0);
      tick();
    end
    reset = 1'b0;
  endtask

  // One transaction from posedge+1; returns the cycle busy was seen low
  // (-1 on timeout) and the read data in that cycle. Ends at posedge+1.
  task automatic xact(input int m, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] wm, input logic rs,
                      output logic [31:0] rd, output int lat);
    logic wr;
    wr  = (wm != 4'b0);
    lat = -1;
    rd  = '0;
    set_req(m, a, d, wm, rs);
    @(negedge clk);
    tick();
    set_req(m, '0, '0, 4'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1)
        chk($sformatf("busy_c1_m%0d", m), {30'b0, m_rbusy[m], m_wbusy[m]}, {30'b0, ~wr, wr});
      if (!m_rbusy[m] && !m_wbusy[m]) begin
        lat = k;
        rd  = m_rdata[m];
        break;
      end
      tick();
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL timeout_m%0d: busy still high after 8 cycles, expected release", m);
    end
    tick();
  endtask

  // Random traffic on a master-private address set; reference is the shadow memory.
  task automatic rand_master(input int m, input int n);
    logic [AW-1:0] a;
    logic [31:0]   d, rd, e;
    logic [3:0]    wm;
    int            lat;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      a = AW'(14'h300 + 2 * $urandom_range(0, 7) + m);
      if ($urandom_range(0, 1) == 1) begin
        wm = 4'($urandom_range(1, 15));
        d  = $urandom;
        for (int b = 0; b < 4; b++)
          if (wm[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
        xact(m, a, d, wm, 1'($urandom_range(0, 1)), rd, lat);
      end else begin
        if (m == 0) exp_q0.push_back(shadow[a]); else exp_q1.push_back(shadow[a]);
        xact(m, a, '0, 4'b0, 1'b1, rd, lat);
        e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk($sformatf("rand_rd_m%0d_%0d", m, i), rd, e);
      end
      chk($sformatf("rand_lat_m%0d_%0d", m, i), 32'(lat >= 1 && lat <= 4), 32'd1);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            m;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wmask;
    logic          rstrb;
    logic [31:0]   exp_rdata;
  } vec_t;
  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    int          issued [2];
    int          strobed_last [2];
    int          grants;

    vecs[0] = '{0, 14'h0004, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0};
    vecs[1] = '{0, 14'h0004, 32'h0,        4'b0000, 1'b1, 32'hDEADBEEF};
    vecs[2] = '{1, 14'h0020, 32'h0,        4'b0000, 1'b1, 32'h0};
    vecs[3] = '{1, 14'h0020, 32'hAABBCCDD, 4'b0100, 1'b0, 32'h0};
    vecs[4] = '{1, 14'h0020, 32'h0,        4'b0000, 1'b1, 32'h00BB0000};
    vecs[5] = '{0, 14'h0004, 32'h12345678, 4'b0011, 1'b1, 32'h0};
    vecs[6] = '{1, 14'h0004, 32'h0,        4'b0000, 1'b1, 32'hDEAD5678};

    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end

    // Power-on reset and reset-state outputs.
    tick();
    do_reset();
    @(negedge clk);
    chk("rst_busy", {28'b0, m_rbusy[0], m_wbusy[0], m_rbusy[1], m_wbusy[1]}, 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_rdata0", m_rdata[0], 32'd0);
    chk("rst_rdata1", m_rdata[1], 32'd0);
    chk("rst_stats", {20'b0, stat_grant[0], stat_grant[1], stat_conflict}, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    tick();

    // Reset in the middle of a write ACCESS drops the write.
    xact(0, 14'h0010, 32'hCAFEF00D, 4'b1111, 1'b0, rd, lat);
    set_req(0, 14'h0010, 32'h0, 4'b1111, 1'b0);
    @(negedge clk);
    tick();
    set_req(0, '0, '0, 4'b0, 1'b0);
    do_reset();
    @(negedge clk);
    chk("rst_mid_word", mem[16], 32'hCAFEF00D);
    chk("rst_mid_busy", {28'b0, m_rbusy[0], m_wbusy[0], m_rbusy[1], m_wbusy[1]}, 32'd0);
    chk("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    tick();

    // Uncontended transactions from the table.
    for (int i = 0; i < 7; i++) begin
      xact(vecs[i].m, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, vecs[i].rstrb, rd, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
      if (vecs[i].wmask == 4'b0) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end
    chk("hold_rdata0", m_rdata[0], 32'hDEADBEEF);

    // Strobe while pending is ignored: M0 read holds the RAM, M1 write waits.
    set_req(0, 14'h0020, '0, 4'b0, 1'b1);
    @(negedge clk);
    tick();
    set_req(0, '0, '0, 4'b0, 1'b0);
    set_req(1, 14'h0030, 32'hAABBCCDD, 4'b0100, 1'b0);
    @(negedge clk);
    tick();
    set_req(1, 14'h0030, 32'hFFFFFFFF, 4'b1111, 1'b1);
    @(negedge clk);
    chk("ign_wbusy1", 32'(m_wbusy[1]), 32'd1);
    tick();
    set_req(1, '0, '0, 4'b0, 1'b0);
    repeat (4) tick();
    @(negedge clk);
    chk("ign_wr_count", 32'(wr30_cnt), 32'd1);
    chk("ign_word", mem[14'h0030], 32'h00BB0000);
    chk("ign_m0_rdata", m_rdata[0], 32'h00BB0000);
    tick();

    // Same-cycle strobes after reset: M0 write wins, M1 reads the new word.
    do_reset();
    set_req(0, 14'h0001, 32'h11223344, 4'b1111, 1'b0);
    set_req(1, 14'h0001, '0, 4'b0, 1'b1);
    @(negedge clk);
    tick();
    set_req(0, '0, '0, 4'b0, 1'b0);
    set_req(1, '0, '0, 4'b0, 1'b0);
    @(negedge clk);
    chk("tie_c1_ram", {27'b0, ram_en, ram_wmask}, {27'b0, 1'b1, 4'b1111});
    chk("tie_c1_busy", {30'b0, m_wbusy[0], m_rbusy[1]}, 32'b11);
    tick();
    @(negedge clk);
    chk("tie_c2_busy", {30'b0, m_wbusy[0], m_rbusy[1]}, 32'b01);
    tick();
    @(negedge clk);
    chk("tie_c3_busy", {30'b0, m_wbusy[0], m_rbusy[1]}, 32'b00);
    chk("tie_c3_rdata1", m_rdata[1], 32'h11223344);
    tick();

    // Both masters re-strobe as soon as busy drops: grants must alternate.
    do_reset();
    issued       = '{0, 0};
    strobed_last = '{0, 0};
    grants       = 0;
    for (int cyc = 0; cyc < 200 && grants < 20; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (!m_rbusy[m] && strobed_last[m] == 0 && issued[m] < 10) begin
          set_req(m, (m == 0) ? 14'h0100 : 14'h0200, '0, 4'b0, 1'b1);
          issued[m]++;
          strobed_last[m] = 1;
        end else begin
          set_req(m, '0, '0, 4'b0, 1'b0);
          strobed_last[m] = 0;
        end
      end
      @(negedge clk);
      if (ram_en) begin
        chk($sformatf("alt_%0d", grants), 32'(ram_addr == 14'h0200), 32'(grants % 2));
        grants++;
      end
      tick();
    end
    set_req(0, '0, '0, 4'b0, 1'b0);
    set_req(1, '0, '0, 4'b0, 1'b0);
    chk("alt_grants", 32'(grants), 32'd20);
    repeat (3) tick();
    @(negedge clk);
`ifdef RAM_ARB_STATS_EN
    chk("alt_stat_g0", 32'(stat_grant[0]), 32'd10);
    chk("alt_stat_g1", 32'(stat_grant[1]), 32'd10);
    chk("alt_conflict_nz", 32'(stat_conflict != '0), 32'd1);
`else
    chk("alt_stat_off", {20'b0, stat_grant[0], stat_grant[1], stat_conflict}, 32'd0);
`endif
    tick();

    // Twenty more M0 grants saturate the narrow counter.
    for (int i = 0; i < 20; i++) begin
      xact(0, 14'h0004, '0, 4'b0, 1'b1, rd, lat);
      chk($sformatf("sat_lat_%0d", i), 32'(lat), 32'd2);
    end
    @(negedge clk);
`ifdef RAM_ARB_STATS_EN
    chk("sat_stat_g0", 32'(stat_grant[0]), 32'hF);
    chk("sat_stat_g1", 32'(stat_grant[1]), 32'd10);
`else
    chk("sat_stat_off", {20'b0, stat_grant[0], stat_grant[1], stat_conflict}, 32'd0);
`endif
    tick();

    // Random concurrent traffic from both masters.
    fork
      rand_master(0, 40);
      rand_master(1, 40);
    join
    chk("rand_q_empty", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
